// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS controller: ALU codes, opcode/funct values,
// datapath mux encodings, the FSM state enum and the ALU-decode class selector.
package mips_pkg;
    localparam int ALU_CTRL_W = 4;
    localparam int OPCODE_W   = 6;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1010;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OPCODE_W-1:0] FN_SLL  = 6'h00;
    localparam logic [OPCODE_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OPCODE_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OPCODE_W-1:0] FN_SUB  = 6'h22;
    localparam logic [OPCODE_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OPCODE_W-1:0] FN_AND  = 6'h24;
    localparam logic [OPCODE_W-1:0] FN_OR   = 6'h25;
    localparam logic [OPCODE_W-1:0] FN_XOR  = 6'h26;
    localparam logic [OPCODE_W-1:0] FN_NOR  = 6'h27;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPE_EX, S_RTYPE_WB, S_IMM_EX, S_IMM_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_IMM
    } alu_cls_e;
endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU decode: (state class, opcode, funct) -> alu_control, imm_zext, legal.
module mips_alu_decode
    import mips_pkg::*;
(
    input  alu_cls_e                alu_cls,
    input  logic [OPCODE_W-1:0]     opcode,
    input  logic [OPCODE_W-1:0]     funct,
    output logic [ALU_CTRL_W-1:0]   alu_control,
    output logic                    imm_zext,
    output logic                    legal
);
    always_comb begin
        alu_control = ALU_AND;
        imm_zext    = 1'b0;
        legal       = 1'b1;
        case (alu_cls)
            CLS_ADD: alu_control = ALU_ADD;
            CLS_SUB: alu_control = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_control = ALU_SUB;
                    FN_AND:          alu_control = ALU_AND;
                    FN_OR:           alu_control = ALU_OR;
                    FN_XOR:          alu_control = ALU_XOR;
                    FN_NOR:          alu_control = ALU_NOR;
                    FN_SLL:          alu_control = ALU_SLL;
                    default: begin
                        alu_control = ALU_ADD;
                        legal       = 1'b0;
                    end
                endcase
            end
            CLS_IMM: begin
                // Logical immediates zero-extend; arithmetic ones sign-extend.
                case (opcode)
                    OP_ADDI, OP_ADDIU: alu_control = ALU_ADD;
                    OP_ANDI: begin alu_control = ALU_AND; imm_zext = 1'b1; end
                    OP_ORI:  begin alu_control = ALU_OR;  imm_zext = 1'b1; end
                    OP_XORI: begin alu_control = ALU_XOR; imm_zext = 1'b1; end
                    default: begin
                        alu_control = ALU_ADD;
                        legal       = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM (fetch/decode/execute/mem/writeback).
// MCTRL_ILLEGAL_TRAP_EN: illegal opcode/funct locks into TRAP with illegal_op=1; otherwise it acts as a NOP.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_W-1:0]     opcode,
    input  logic [OPCODE_W-1:0]     funct,
    input  logic                    alu_zero,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    iord,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic                    imm_zext,
    output logic [1:0]              pc_source,
    output logic [ALU_CTRL_W-1:0]   alu_control
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_op
`endif
);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    localparam state_e S_ILLEGAL = S_TRAP;
`else
    localparam state_e S_ILLEGAL = S_FETCH;
`endif

    state_e   state_q, state_d;
    alu_cls_e alu_cls;
    logic     legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Class selection depends on state only, so the legal feedback below is loop-free.
    always_comb begin
        case (state_q)
            S_FETCH, S_DECODE, S_MEMADR: alu_cls = CLS_ADD;
            S_RTYPE_EX:                  alu_cls = CLS_RTYPE;
            S_IMM_EX:                    alu_cls = CLS_IMM;
            S_BRANCH:                    alu_cls = CLS_SUB;
            default:                     alu_cls = CLS_NONE;
        endcase
    end

    mips_alu_decode u_alu_decode (
        .alu_cls     (alu_cls),
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (alu_control),
        .imm_zext    (imm_zext),
        .legal       (legal)
    );

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        pc_source  = PCSRC_ALU;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched.
                alu_src_b = SRCB_BROFF;
                case (opcode)
                    OP_RTYPE:                                  state_d = S_RTYPE_EX;
                    OP_LW, OP_SW:                              state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
                    OP_J:                                      state_d = S_JUMP;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IMM_EX;
                    default:                                   state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                state_d   = legal ? S_RTYPE_WB : S_ILLEGAL;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_source = PCSRC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? !alu_zero : alu_zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                illegal_op = 1'b1;
`endif
                state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
